// File: rtl/somador_serial.sv
// somador_serial: bit-serial N-bit adder, one full-adder cell reused LSB-first over N cycles
module somador_serial #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic         V,
    output logic         busy,
    output logic         done
);
    localparam int CW = $clog2(N) + 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state;
    logic [N-1:0] ra, rb, rr, rr_next;
    logic [CW-1:0] cnt;
    logic c, s_bit, c_next;
    assign s_bit   = ra[0] ^ rb[0] ^ c;
    assign c_next  = (ra[0] & rb[0]) | (c & (ra[0] ^ rb[0]));
    assign rr_next = {s_bit, rr[N-1:1]};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            rr    <= '0;
            cnt   <= '0;
            c     <= 1'b0;
            S     <= '0;
            Cout  <= 1'b0;
            V     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    ra    <= A;
                    rb    <= B;
                    c     <= Cin;
                    cnt   <= '0;
                    rr    <= '0;
                    busy  <= 1'b1;
                    state <= SHIFT;
                end
                SHIFT: begin
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    c   <= c_next;
                    rr  <= rr_next;
                    cnt <= cnt + CW'(1);
                    // c here is the carry into the MSB, so V = carry-in(MSB) ^ carry-out
                    if (cnt == CW'(N - 1)) begin
                        S     <= rr_next;
                        Cout  <= c_next;
                        V     <= c ^ c_next;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_somador_serial.sv
// tb_somador_serial: directed and random checks of the serial adder against plain arithmetic
module tb_somador_serial;
    localparam int N = 8;
    logic clk = 1'b0;
    logic rst, start, Cin;
    logic [N-1:0] A, B, S;
    logic Cout, V, busy, done;
    int total = 0;
    int bad = 0;
    logic [N-1:0] exp_s = '0;
    logic exp_c = 1'b0;
    logic exp_v = 1'b0;

    somador_serial #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Cin(Cin),
        .S(S), .Cout(Cout), .V(V), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    // Reference: plain integer addition; signed overflow from operand/result signs
    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci,
                         output logic [N-1:0] s, output logic co, output logic v);
        int unsigned sum;
        sum = int'(a) + int'(b) + int'(ci);
        s = sum[N-1:0];
        co = sum[N];
        v = (a[N-1] == b[N-1]) && (s[N-1] != a[N-1]);
    endtask

    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci,
                          input bit noise);
        logic [N-1:0] ns;
        logic nc, nv;
        model(a, b, ci, ns, nc, nv);
        @(negedge clk);
        A = a; B = b; Cin = ci; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", {8'd0, busy}, 9'd1);
        chk("done_after_start", {8'd0, done}, 9'd0);
        for (int i = 1; i <= N; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (i < N) begin
                chk("done_early", {8'd0, done}, 9'd0);
                chk("busy_mid", {8'd0, busy}, 9'd1);
                chk("hold_mid", {S, Cout}, {exp_s, exp_c});
                chk("hold_v_mid", {8'd0, V}, {8'd0, exp_v});
                if (noise && (i == 1 || i == 4)) begin
                    A = N'($urandom); B = N'($urandom); Cin = 1'($urandom); start = 1'b1;
                end
            end else begin
                chk("done_pulse", {busy, done}, 9'b01);
                chk("sum_cout", {S, Cout}, {ns, nc});
                chk("ovf", {8'd0, V}, {8'd0, nv});
            end
        end
        exp_s = ns; exp_c = nc; exp_v = nv;
        @(posedge clk);
        #1;
        chk("done_one_cycle", {busy, done}, 9'b00);
        chk("hold_after", {S, Cout}, {exp_s, exp_c});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
        #12;
        chk("reset_outs", {S, Cout}, 9'd0);
        chk("reset_ctl", {6'd0, V, busy, done}, 9'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h3C, 8'h05, 1'b0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 0);
        run_op(8'h7F, 8'h01, 1'b0, 0);
        run_op(8'h05, ~8'h07, 1'b1, 0);
        run_op(8'h07, ~8'h05, 1'b1, 0);
        run_op(8'h80, 8'h80, 1'b0, 0);
        run_op(8'hA5, 8'h5A, 1'b1, 1);
        // Abort mid-operation with an asynchronous reset
        @(negedge clk);
        A = 8'hC3; B = 8'h99; Cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_outs", {S, Cout}, 9'd0);
        chk("rst_mid_ctl", {6'd0, V, busy, done}, 9'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_s = '0; exp_c = 1'b0; exp_v = 1'b0;
        repeat (N + 2) begin
            @(posedge clk);
            #1;
            chk("no_done_after_rst", {busy, done}, 9'd0);
        end
        run_op(8'hC3, 8'h99, 1'b1, 0);
        for (int k = 0; k < 400; k++)
            run_op(N'($urandom), N'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
